// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: request/result bundle between the execute stage and the
// iterative multiply/divide unit.
//   master (execute stage): drives flush, start, op, a, b
//   slave  (muldiv unit)  : drives busy, stall, done, hi, lo, div_by_zero, illegal
// op encoding: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 64
);
  logic             flush;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  logic             illegal;

  modport master (
    output flush, start, op, a, b,
    input  busy, stall, done, hi, lo, div_by_zero, illegal
  );

  modport slave (
    input  flush, start, op, a, b,
    output busy, stall, done, hi, lo, div_by_zero, illegal
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Operands are reduced to magnitudes on acceptance. The unit then retires STEP
// bits per cycle for N = WIDTH/STEP cycles (RUN). It applies the sign
// correction and writes HI/LO in one final cycle (SIGN).
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   bus (slave)  : flush/start/op/a/b in; busy/stall/done/hi/lo/div_by_zero/illegal out
// Build option: define MULDIV_DIV_EN to include the divider. Without it, divide
// requests are refused with a one-cycle illegal pulse and the unit stays idle.
module ex_muldiv_unit #(
  parameter int WIDTH = 64,
  parameter int STEP  = 1
) (
  input logic             clock,
  input logic             reset,
  ex_muldiv_unit_if.slave bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SIGN = 2'd2} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic               neg_q;      // negate product / quotient
  logic               rem_neg_q;  // remainder follows the dividend sign
  logic               dbz_q;
  logic [WIDTH-1:0]   opb_q;      // |b|: multiplicand or divisor
  // Shared accumulator. Multiply: {partial high, remaining multiplier bits}.
  // Divide: {partial remainder, dividend bits still to shift / quotient bits}.
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               dbz_out_q;
  logic               illegal_q;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    a_neg;
  logic                    b_neg;
  logic [WIDTH-1:0]        a_mag;
  logic [WIDTH-1:0]        b_mag;
  logic [WIDTH+STEP-1:0]   mul_pp;
  logic [WIDTH+STEP-1:0]   mul_sum;

  function automatic logic [WIDTH-1:0] neg_w(input logic n, input logic [WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_d(input logic n, input logic [2*WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  assign a_s   = bus.a;
  assign b_s   = bus.b;
  assign a_neg = bus.op[0] && (a_s < 0);
  assign b_neg = bus.op[0] && (b_s < 0);
  assign a_mag = neg_w(a_neg, bus.a);
  assign b_mag = neg_w(b_neg, bus.b);

  // Shift-add: STEP low multiplier bits select a partial product that is added
  // to the running high half, then the whole accumulator shifts right by STEP.
  assign mul_pp  = {{STEP{1'b0}}, opb_q} * {{WIDTH{1'b0}}, acc_q[STEP-1:0]};
  assign mul_sum = {{STEP{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + mul_pp;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-1:0] quo_w;
  logic [WIDTH:0]   trial_w;
`endif

  always_comb begin
    acc_d = {mul_sum, acc_q[WIDTH-1:STEP]};
`ifdef MULDIV_DIV_EN
    // Restoring division, STEP quotient bits per cycle. The remainder always
    // stays below the divisor, so the WIDTH+1 bit trial never loses its top bit.
    rem_w   = acc_q[2*WIDTH-1:WIDTH];
    quo_w   = acc_q[WIDTH-1:0];
    trial_w = '0;
    for (int i = 0; i < STEP; i++) begin
      trial_w = {rem_w, quo_w[WIDTH-1]};
      quo_w   = {quo_w[WIDTH-2:0], 1'b0};
      if (trial_w >= {1'b0, opb_q}) begin
        trial_w  = trial_w - {1'b0, opb_q};
        quo_w[0] = 1'b1;
      end
      rem_w = trial_w[WIDTH-1:0];
    end
    if (is_div_q) acc_d = {rem_w, quo_w};
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      opb_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.flush) begin
`ifndef MULDIV_DIV_EN
            if (bus.op[1]) illegal_q <= 1'b1;
            else
`endif
            begin
              state_q   <= RUN;
              cnt_q     <= CW'(N - 1);
              is_div_q  <= bus.op[1];
              neg_q     <= a_neg ^ b_neg;
              rem_neg_q <= a_neg;
              dbz_q     <= bus.op[1] && (bus.b == '0);
              opb_q     <= b_mag;
              acc_q     <= {{WIDTH{1'b0}}, a_mag};
            end
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) state_q <= SIGN;
          end
        end
        SIGN: begin
          state_q <= IDLE;
          if (!bus.flush) begin
            done_q    <= 1'b1;
            dbz_out_q <= dbz_q;
            if (is_div_q) begin
              // Divide by zero leaves the dividend in the remainder half, so the
              // normal remainder path already yields HI = a.
              lo_q <= dbz_q ? '1 : neg_w(neg_q, acc_q[WIDTH-1:0]);
              hi_q <= neg_w(rem_neg_q, acc_q[2*WIDTH-1:WIDTH]);
            end else begin
              {hi_q, lo_q} <= neg_d(neg_q, acc_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.stall       = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_out_q;
  assign bus.illegal     = illegal_q;
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Parametrised iterative multiply/divide unit attached to the execute stage. It accepts one MULT/MULTU/DIV/DIVU request at a time and computes it over several cycles, retiring `STEP` bits per cycle. Results are held in architectural HI/LO registers. While it is busy, `stall` freezes the ID/EX boundary; `flush` aborts the operation without touching HI/LO.

## Interface
- `WIDTH`, default 64: operand/result width. Must be a multiple of `STEP`.
- `STEP`, default 1: bits retired per iteration. Legal values are 1, 2, 4. Call `N = WIDTH/STEP`.

Ports (name, direction, width, meaning):
- `clock` in 1: Clock is `clock`.
- `reset` in 1: Reset is `reset`, asynchronous, active-high.
- `flush` in 1: abort the in-flight op. Priority over `start`.
- `start` in 1: request, sampled only in IDLE.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`, `b` in WIDTH: forwarded operands, sampled with `start`.
- `busy` out 1: state != IDLE.
- `stall` out 1: equals `busy`. Holds ID/EX and blocks MFHI/MFLO.
- `done` out 1: one-cycle pulse; HI/LO are updated on the same edge.
- `hi`, `lo` out WIDTH: architectural HI/LO.
- `div_by_zero` out 1: pulses with `done` for a divide with b==0.
- `illegal` out 1: one-cycle pulse; see Configuration.

## Operation
- **States:** IDLE, RUN, SIGN.
- **IDLE → RUN** when `start && !flush`:
  - latch `op`;
  - latch |a| and |b| (magnitudes for signed ops, raw for unsigned);
  - latch result-sign flags;
  - counter = N-1.
- **RUN:** each edge retires `STEP` bits.
  - Multiply: shift-add into a 2*WIDTH accumulator, STEP partial-product bits per edge.
  - Divide: restoring, STEP quotient bits per edge.
  - RUN → SIGN when the counter is 0.
- **SIGN → IDLE:** apply sign correction, write HI/LO, pulse `done`.
- **Multiply result:** full 2*WIDTH product; HI = upper half, LO = lower half. Signed ops negate the product when sign(a) != sign(b).
- **Divide result:** LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero.
  - Signed remainder takes the sign of the dividend.
  - MIN / -1 gives LO = MIN, HI = 0.
- **Divide by zero:** same latency as a normal divide. LO = all ones, HI = a, and `div_by_zero` pulses with `done`.
- **`start` while busy:** ignored; no queuing. The pipeline is stalled, so a legal producer never does this.
- **`flush`** in RUN or SIGN: next edge → IDLE. HI/LO are unchanged and `done` is not asserted.
- **`flush` with `start` in IDLE:** the request is dropped.
- **Reset (any time, including mid-op):**
  - state = IDLE;
  - HI = LO = 0;
  - `done` = `div_by_zero` = `illegal` = 0;
  - all datapath registers = 0.

## Timing
- Start accepted at edge E0.
- RUN occupies edges E1..EN; SIGN occurs at edge EN+1.
- `done`, `div_by_zero` and new HI/LO are visible in the cycle after EN+1.
- `busy` is high from after E0 through EN+1 inclusive, and low in the `done` cycle.
- A back-to-back `start` is accepted in the `done` cycle.
- Latency start → `done` = N+2 cycles: 66 for WIDTH=64/STEP=1, 18 for STEP=4.
- All outputs are registered except `busy`/`stall`, which decode directly from the state register.

## Configuration
- **`MULDIV_DIV_EN` defined:** the divider datapath is compiled in; DIV/DIVU behave as above and `illegal` is constantly 0.
- **`MULDIV_DIV_EN` undefined:** no divider hardware.
  - `start` with op[1]=1 stays in IDLE; `busy` is never asserted.
  - `illegal` pulses in the cycle after E0; HI/LO are unchanged.
  - The pulse feeds reserved_inst_E.
  - Multiplies are unaffected.

## Test plan
WIDTH=64, STEP=1 unless noted.
- MULTU a=0xFFFF_FFFF_FFFF_FFFF, b=2 → HI=1, LO=0xFFFF_FFFF_FFFF_FFFE; `done` exactly 66 cycles after `start`; `busy` high for 65 cycles.
- MULT a=-3, b=5 → HI=0xFFFF_FFFF_FFFF_FFFF, LO=0xFFFF_FFFF_FFFF_FFF1. Back-to-back MULT in the `done` cycle, a=-3, b=-5 → HI=0, LO=15.
- DIVU a=100, b=7 → LO=14, HI=2. DIV a=-7, b=2 → LO=-3, HI=-1. DIV a=0x8000_0000_0000_0000, b=-1 → LO=0x8000_0000_0000_0000, HI=0.
- DIV a=5, b=0 → LO=all ones, HI=5, with `div_by_zero`=1 coincident with `done`.
- HI/LO preloaded by a MULTU giving HI=1, LO=2, then start DIVU:
  - Flush 10 cycles into RUN → `busy` low next cycle, `done` never pulses, HI=1/LO=2 retained.
  - Reset asserted mid-RUN → HI=LO=0, IDLE.
- STEP=4: MULTU 0x10 × 0x10 → LO=0x100, `done` 18 cycles after `start`.
- Built without `MULDIV_DIV_EN`, DIV request → `illegal` one-cycle pulse, `busy` stays 0.
